dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory subsystem consuming the single-cycle core's data port (addr, wr_en, wdata, wmask → rdata). Provides a byte-maskable 64-bit data RAM plus a memory-mapped I/O window holding a free-running cycle counter and a byte-wide transmit FIFO with a valid/ready drain port. Reads are combinational so the core completes loads in one cycle; all state updates are on the rising clock edge.

## Interface
- ADDR_W, 10: doubleword-index width of the data RAM (2^ADDR_W × 64 bit).
- DEPTH, 4: TX FIFO entries; power of 2, 2..128.
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- addr  in  32  byte address from the core; bits [2:0] ignored.
- wr_en  in  1  store strobe for this cycle.
- wdata  in  64  store data; byte i = wdata[8i+7:8i].
- wmask  in  8  byte enables; bit i gates byte i.
- rdata  out  64  combinational read data for addr.
- tx_valid  out  1  FIFO head holds a byte.
- tx_ready  in  1  consumer accepts head this cycle.
- tx_data  out  8  FIFO head byte; 0 when empty.

## Operation
- Decode: addr[31:28]==4'hF selects MMIO; otherwise RAM at doubleword index addr[ADDR_W+2:3] (upper bits ignored, aliasing).
- RAM: on posedge with wr_en, each byte i with wmask[i]=1 written; others retained. Contents not cleared by reset. rdata = stored doubleword, unmasked (core performs sub-word extension).
- MMIO map (offset = addr[7:3]; other offsets read 0, writes ignored):
  - 0xF000_0000 CYCLE: read 64-bit counter. Write loads masked bytes of wdata; unmasked bytes take counter+1. Otherwise counter increments by 1 each cycle, wraps 2^64−1 → 0.
  - 0xF000_0008 TX_DATA: write with wmask[0]=1 pushes wdata[7:0]. If full (and no simultaneous pop), byte dropped, overflow sticky set. Reads return 0.
  - 0xF000_0010 STATUS: read bit0 full, bit1 empty, bit2 overflow, bits[15:8] entry count, rest 0. Write with wmask[0]=1 and wdata[2]=1 clears overflow.
- FIFO: circular buffer, read/write pointers, count register. Pop when tx_valid && tx_ready. Push and pop same cycle: both occur, count unchanged; when full this push is accepted (no overflow). Push into empty FIFO: no bypass, byte visible on tx_data next cycle.
- Overflow set and clear in same cycle: set wins.

## Timing
- Reset (nrst=0 at posedge): counter=0, FIFO empty, pointers=0, overflow=0; hence tx_valid=0, tx_data=0, STATUS reads 0x0000_0000_0000_0002. nrst low mid-operation flushes FIFO contents without draining; RAM unaffected.
- Read latency 0: rdata is combinational from addr and current register/RAM state; a load to an address written the same cycle returns pre-write data.
- Write latency 1: effect visible on rdata / tx_valid / STATUS the cycle after the store edge.
- CYCLE read at cycle n after reset release returns n (first post-reset cycle reads 0).
- tx_valid/tx_data change only on clock edges; tx_data stable while tx_valid=1 and tx_ready=0.
- FIFO accepts one push and delivers one pop per cycle maximum.

## Test plan
- RAM byte mask: store 0x1122_3344_5566_7788 to 0x40 mask 0xFF, then 0xAAAA… to 0x40 mask 0x0F → load 0x40 returns 0x1122_3344_AAAA_AAAA; load 0x44 returns the same (low bits ignored).
- Counter: release reset, read CYCLE over 5 cycles → 0,1,2,3,4; write 0xFFFF_FFFF_FFFF_FFFE mask 0xFF → next cycle reads ...FE, then ...FF, then 0.
- FIFO fill/overflow, DEPTH=4, tx_ready=0: push 0x41..0x45 → STATUS = 0x0000_0000_0000_0405 (count 4, full, overflow); tx_data=0x41; write STATUS wdata=0x4 → overflow cleared.
- Drain with backpressure: tx_ready toggling 1,0,1,1 → bytes 0x41,0x42,0x43 accepted in order only on ready cycles; tx_data held during stall; empty after last pop → tx_valid=0, tx_data=0, STATUS bit1=1.
- Simultaneous push/pop at full: 4 entries, tx_ready=1 and push 0x5A same cycle → count stays 4, overflow stays 0, 0x5A emerges after remaining three bytes.
- Reset mid-operation: FIFO with 3 entries, counter ~100, nrst low one cycle → tx_valid=0, STATUS=0x2, CYCLE=0, previously written RAM word still reads back unchanged.

Source files
------------

// File: rtl/dmem_mmio_if.sv
// Core data-port bus plus the TX drain port for dmem_mmio.
// The master side is the core and the byte consumer together, so it also drives tx_ready.
interface dmem_mmio_if;
    logic [31:0] addr;
    logic        wr_en;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;

    modport master (
        output addr, wr_en, wdata, wmask, tx_ready,
        input  rdata, tx_valid, tx_data
    );

    modport slave (
        input  addr, wr_en, wdata, wmask, tx_ready,
        output rdata, tx_valid, tx_data
    );
endinterface

// File: rtl/dmem_mmio.sv
// Data memory for the single-cycle core: byte-maskable RAM with combinational reads,
// plus an MMIO window at 0xF000_0000 holding a cycle counter and a byte-wide TX FIFO.
module dmem_mmio #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input logic       clk,
    input logic       nrst,
    dmem_mmio_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [4:0] OFF_CYCLE  = 5'd0;
    localparam logic [4:0] OFF_TX     = 5'd1;
    localparam logic [4:0] OFF_STATUS = 5'd2;

    logic [63:0]       mem [2**ADDR_W];
    logic [63:0]       cycle_cnt;
    logic [63:0]       cycle_inc;
    logic [7:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    logic              is_mmio;
    logic [4:0]        offset;
    logic [ADDR_W-1:0] ram_idx;
    logic              ram_we;
    logic              cyc_we;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              ovf_set;
    logic              ovf_clr;
    logic [63:0]       status;
    logic              unused_addr;

    assign is_mmio  = (bus.addr[31:28] == 4'hF);
    assign offset   = bus.addr[7:3];
    assign ram_idx  = bus.addr[ADDR_W+2:3];
    assign unused_addr = ^{bus.addr[27:ADDR_W+3], bus.addr[2:0]};

    assign ram_we   = bus.wr_en && !is_mmio;
    assign cyc_we   = bus.wr_en && is_mmio && (offset == OFF_CYCLE);
    assign push_req = bus.wr_en && is_mmio && (offset == OFF_TX) && bus.wmask[0];
    assign ovf_clr  = bus.wr_en && is_mmio && (offset == OFF_STATUS) && bus.wmask[0] && bus.wdata[2];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop      = !empty && bus.tx_ready;
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    assign cycle_inc = cycle_cnt + 64'd1;
    assign status    = {48'd0, 8'(count), 5'd0, overflow, empty, full};

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.wmask[i]) mem[ram_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cycle_cnt <= '0;
        end else if (cyc_we) begin
            for (int i = 0; i < 8; i++) begin
                cycle_cnt[8*i +: 8] <= bus.wmask[i] ? bus.wdata[8*i +: 8] : cycle_inc[8*i +: 8];
            end
        end else begin
            cycle_cnt <= cycle_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.wdata[7:0];
    end

    // Reset flushes by pointer only; stale bytes in fifo_mem are never exposed.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    always_comb begin
        bus.rdata = 64'd0;
        if (is_mmio) begin
            case (offset)
                OFF_CYCLE:  bus.rdata = cycle_cnt;
                OFF_STATUS: bus.rdata = status;
                default:    bus.rdata = 64'd0;
            endcase
        end else begin
            bus.rdata = mem[ram_idx];
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus a randomized phase,
// all compared against a behavioural model built from queues and associative arrays.
module tb_dmem_mmio;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam logic [31:0] CYC_A = 32'hF000_0000;
    localparam logic [31:0] TX_A  = 32'hF000_0008;
    localparam logic [31:0] STA_A = 32'hF000_0010;

    logic clk;
    logic nrst;
    dmem_mmio_if bus();

    dmem_mmio #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_compared;
    int          n_mismatched;
    logic [63:0] ram_m [int];
    logic [7:0]  q_m [$];
    logic [63:0] cyc_m;
    logic        ovf_m;
    logic        model_valid;
    logic [63:0] last_rdata;
    logic        last_txv;
    logic [7:0]  last_txd;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic applyStimulus(input logic rst_n, input logic [31:0] a, input logic we,
                                 input logic [63:0] wd, input logic [7:0] wm, input logic rdy);
        logic        mmio;
        logic [4:0]  off;
        int          idx;
        logic [63:0] exp_rd;
        logic        chk_rd;
        logic [63:0] inc;
        logic        pop_m;
        logic        push_req;
        logic        set_m;
        logic        clr_m;
        @(negedge clk);
        nrst         = rst_n;
        bus.addr     = a;
        bus.wr_en    = we;
        bus.wdata    = wd;
        bus.wmask    = wm;
        bus.tx_ready = rdy;
        #1;
        last_rdata = bus.rdata;
        last_txv   = bus.tx_valid;
        last_txd   = bus.tx_data;
        mmio = (a[31:28] == 4'hF);
        off  = a[7:3];
        idx  = int'(a[ADDR_W+2:3]);
        if (model_valid) begin
            chk_rd = 1'b1;
            exp_rd = 64'd0;
            if (mmio) begin
                if (off == 5'd0) exp_rd = cyc_m;
                else if (off == 5'd2)
                    exp_rd = {48'd0, 8'(q_m.size()), 5'd0, ovf_m, (q_m.size() == 0), (q_m.size() == DEPTH)};
            end else if (ram_m.exists(idx)) begin
                exp_rd = ram_m[idx];
            end else begin
                chk_rd = 1'b0;
            end
            if (chk_rd) checkOutput("rdata", bus.rdata, exp_rd);
            checkOutput("tx_valid", 64'(bus.tx_valid), 64'(q_m.size() != 0));
            checkOutput("tx_data", 64'(bus.tx_data), (q_m.size() != 0) ? 64'(q_m[0]) : 64'd0);
        end
        if (we && !mmio) begin
            if (!ram_m.exists(idx)) ram_m[idx] = 'x;
            for (int i = 0; i < 8; i++) if (wm[i]) ram_m[idx][8*i +: 8] = wd[8*i +: 8];
        end
        if (!rst_n) begin
            cyc_m = 64'd0;
            q_m.delete();
            ovf_m = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            inc = cyc_m + 64'd1;
            if (mmio && we && off == 5'd0) begin
                for (int i = 0; i < 8; i++) cyc_m[8*i +: 8] = wm[i] ? wd[8*i +: 8] : inc[8*i +: 8];
            end else begin
                cyc_m = inc;
            end
            pop_m    = (q_m.size() != 0) && rdy;
            push_req = mmio && we && (off == 5'd1) && wm[0];
            set_m    = push_req && (q_m.size() == DEPTH) && !pop_m;
            clr_m    = mmio && we && (off == 5'd2) && wm[0] && wd[2];
            if (pop_m) void'(q_m.pop_front());
            if (push_req && !set_m) q_m.push_back(wd[7:0]);
            if (set_m) ovf_m = 1'b1;
            else if (clr_m) ovf_m = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [63:0] wd;
        int          kind;
        n_compared   = 0;
        n_mismatched = 0;
        model_valid  = 1'b0;
        cyc_m        = 64'd0;
        ovf_m        = 1'b0;
        nrst         = 1'b0;
        bus.addr     = STA_A;
        bus.wr_en    = 1'b0;
        bus.wdata    = 64'd0;
        bus.wmask    = 8'd0;
        bus.tx_ready = 1'b0;

        applyStimulus(1'b0, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        applyStimulus(1'b0, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, CYC_A, 1'b0, 64'd0, 8'h00, 1'b0);
            checkOutput("cycle_after_reset", last_rdata, 64'(i));
        end
        applyStimulus(1'b1, CYC_A, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b0);
        applyStimulus(1'b1, CYC_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("cycle_load", last_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(1'b1, CYC_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("cycle_max", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b1, CYC_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("cycle_wrap", last_rdata, 64'd0);

        applyStimulus(1'b1, 32'h40, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("ram_bytemask", last_rdata, 64'h1122_3344_AAAA_AAAA);
        applyStimulus(1'b1, 32'h44, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("ram_lowbits", last_rdata, 64'h1122_3344_AAAA_AAAA);

        for (int w = 0; w < 16; w++)
            if (w != 8) applyStimulus(1'b1, 32'(w * 8), 1'b1, {$urandom, $urandom}, 8'hFF, 1'b0);

        for (int b = 8'h41; b <= 8'h45; b++)
            applyStimulus(1'b1, TX_A, 1'b1, {$urandom, $urandom_range(0, 16777215), 8'(b)}, 8'h01, 1'b0);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("status_full_ovf", last_rdata, 64'h0000_0000_0000_0405);
        checkOutput("head_byte", 64'(last_txd), 64'h41);
        applyStimulus(1'b1, STA_A, 1'b1, 64'h4, 8'h01, 1'b0);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("ovf_cleared", last_rdata, 64'h0000_0000_0000_0401);

        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("stall_hold", 64'(last_txd), 64'h42);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("empty_valid", 64'(last_txv), 64'd0);
        checkOutput("empty_data", 64'(last_txd), 64'd0);
        checkOutput("empty_status", last_rdata, 64'h2);

        for (int b = 8'h11; b <= 8'h14; b++)
            applyStimulus(1'b1, TX_A, 1'b1, 64'(b), 8'h01, 1'b0);
        applyStimulus(1'b1, TX_A, 1'b1, 64'h5A, 8'h01, 1'b1);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("full_pushpop_status", last_rdata, 64'h0000_0000_0000_0401);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("full_pushpop_tail", 64'(last_txd), 64'h5A);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b1);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            a = $urandom;
            if (kind <= 3) begin
                a[31:28] = 4'($urandom_range(0, 14));
                a[12:3]  = 10'($urandom_range(0, 15));
            end else begin
                a[31:28] = 4'hF;
                case (kind)
                    4, 9:    a[7:3] = 5'd0;
                    5, 6:    a[7:3] = 5'd1;
                    7:       a[7:3] = 5'd2;
                    default: a[7:3] = 5'($urandom_range(3, 31));
                endcase
            end
            wd = {$urandom, $urandom};
            applyStimulus(1'b1, a, 1'($urandom_range(0, 1)), wd, 8'($urandom), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, CYC_A, 1'b0, 64'd0, 8'h00, 1'b1);
        applyStimulus(1'b1, 32'h78, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b0);
        for (int b = 1; b <= 3; b++) applyStimulus(1'b1, TX_A, 1'b1, 64'(8'h60 + b), 8'h01, 1'b0);
        applyStimulus(1'b1, CYC_A, 1'b1, 64'd100, 8'hFF, 1'b0);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("pre_reset_status", last_rdata, 64'h0000_0000_0000_0300);
        applyStimulus(1'b0, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        applyStimulus(1'b1, CYC_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("rst_cycle", last_rdata, 64'd0);
        checkOutput("rst_valid", 64'(last_txv), 64'd0);
        applyStimulus(1'b1, STA_A, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("rst_status", last_rdata, 64'h2);
        applyStimulus(1'b1, 32'h78, 1'b0, 64'd0, 8'h00, 1'b0);
        checkOutput("rst_ram_kept", last_rdata, 64'hDEAD_BEEF_0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
